// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with pin synchronisation, clock
// deglitch filter, 11-bit frame decoder, stall timeout and a
// first-word-fall-through byte FIFO with a valid/ready read port.
// Optional build macro: PS2_RX_PARITY_CHECK_EN (when undefined, the parity
// bit is sampled but ignored and parity_err stays low).
module ps2_rx #(
    parameter int DEPTH          = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    output logic [7:0]                   rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         parity_err,
    output logic                         frame_err,
    output logic                         overflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int FW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk, r_filt_d;
    logic [FW-1:0] r_filt_cnt;
    state_t        r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shreg;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          r_parity_err, r_frame_err, r_overflow;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_rd_data;

    logic          w_fall, w_data, w_par_ok, w_push;
    logic          w_full, w_pop, w_wr_en;
    logic [AW-1:0] w_rd_ptr_next;
    logic [CW-1:0] w_count_next;

    // Two-flop synchronisers on both pins; idle-high bus state after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows the synchronised pin only after FILTER_LEN
    // consecutive samples disagree with it; any agreeing sample restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_clk <= 1'b1;
            r_filt_d   <= 1'b1;
            r_filt_cnt <= '0;
        end else begin
            r_filt_d <= r_filt_clk;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + FW'(1);
            end
        end
    end

    assign w_fall   = r_filt_d & ~r_filt_clk;
    assign w_data   = r_dat_s2;
    assign w_par_ok = PAR_CHECK ? (^r_shreg ^ r_parity) : 1'b1;
    assign w_push   = w_fall & (r_state == S_STOP) & w_data & w_par_ok;

    // Frame decoder plus stall timeout; error pulses are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_shreg      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == S_IDLE || w_fall) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_data) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shreg[r_bitcnt] <= w_data;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_parity <= w_data;
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (!w_data) begin
                            r_frame_err <= 1'b1;
                        end else if (!w_par_ok) begin
                            r_parity_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE && r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_frame_err <= 1'b1;
                r_state     <= S_IDLE;
            end
        end
    end

    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = (r_count != '0) & rd_ready;
    assign w_wr_en       = w_push & (~w_full | w_pop);
    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_en && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr_en && w_pop) begin
            w_count_next = r_count - CW'(1);
        end
    end

    // FIFO storage array, written without reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shreg;
        end
    end

    // Pointers, occupancy, overflow pulse and the registered head-of-FIFO
    // read; a byte written into the slot about to become head is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= 8'h00;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_count_next == '0) begin
                r_rd_data <= 8'h00;
            end else if (w_wr_en && r_wr_ptr == w_rd_ptr_next) begin
                r_rd_data <= r_shreg;
            end else begin
                r_rd_data <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign rd_data    = r_rd_data;
    assign rd_valid   = (r_count != '0);
    assign count      = r_count;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed self-checking bench for ps2_rx.
module tb_ps2_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    int n_chk = 0;
    int n_err = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_ovf = 0;

    ps2_rx #(.DEPTH(8), .FILTER_LEN(4), .TIMEOUT_CYCLES(200)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Count cycles each pulse output is high (sampled mid-cycle).
    always @(negedge clk) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    // Drive nbits of an 11-bit frame; ps2_clk half period 20 clk cycles.
    // glitch_at >= 0 inserts a 3-cycle low pulse on ps2_clk before that bit.
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                              input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_at) begin
                wait_clk(3);
                ps2_clk = 1'b0;
                wait_clk(3);
                ps2_clk = 1'b1;
                wait_clk(4);
            end else begin
                wait_clk(10);
            end
            ps2_clk = 1'b0;
            wait_clk(20);
            ps2_clk = 1'b1;
            wait_clk(10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1, 11, -1);
        wait_clk(20);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {24'd0, rd_data}, {24'd0, exp});
        rd_ready = 1'b1;
        wait_clk(1);
        rd_ready = 1'b0;
    endtask

    initial begin : stim
        int base_p, base_f, base_o;
        logic [7:0] exp_b;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rd_ready = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(1);

        // Reset state
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_data", {24'd0, rd_data}, 32'h00);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        wait_clk(50);

        // 1: single good byte 0x1C (parity 0), then pop
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        wait_clk(20);
        check("t1_count", {28'd0, count}, 32'd1);
        pop_expect("t1_data", 8'h1C);
        check("t1_count_after", {28'd0, count}, 32'd0);
        check("t1_valid_after", {31'd0, rd_valid}, 32'd0);

        // 2: 0xF0 with wrong parity bit 0
        base_p = n_perr;
        send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
        wait_clk(20);
`ifdef PS2_RX_PARITY_CHECK_EN
        check("t2_perr_pulse", n_perr - base_p, 32'd1);
        check("t2_count", {28'd0, count}, 32'd0);
`else
        check("t2_perr_none", n_perr - base_p, 32'd0);
        check("t2_count", {28'd0, count}, 32'd1);
        pop_expect("t2_data", 8'hF0);
`endif

        // 3: nine bytes without reading -> full at 8, ninth dropped
        base_o = n_ovf;
        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        check("t3_count_full", {28'd0, count}, 32'd8);
        check("t3_no_ovf_yet", n_ovf - base_o, 32'd0);
        send_byte(8'h09);
        check("t3_count_still8", {28'd0, count}, 32'd8);
        check("t3_ovf_pulse", n_ovf - base_o, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            exp_b = 8'(k);
            pop_expect("t3_drain", exp_b);
        end
        check("t3_empty", {31'd0, rd_valid}, 32'd0);

        // 4: stalled frame (start + 3 data bits) -> timeout frame_err
        base_f = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b0, 4, -1);
        for (int c = 0; c < 400; c++) begin
            if (n_ferr != base_f) break;
            wait_clk(1);
        end
        wait_clk(2);
        check("t4_timeout_ferr", n_ferr - base_f, 32'd1);
        check("t4_count", {28'd0, count}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
        wait_clk(20);
        check("t4_count_after", {28'd0, count}, 32'd1);
        pop_expect("t4_data", 8'h5A);

        // 5a: bad stop bit
        base_f = n_ferr;
        send_frame(8'h33, 1'b1, 1'b0, 11, -1);
        wait_clk(20);
        check("t5_stop_ferr", n_ferr - base_f, 32'd1);
        check("t5_count", {28'd0, count}, 32'd0);

        // 5b: fill, then push 0x44 while popping in the same cycle
        for (int k = 0; k < 8; k++) send_byte(8'h60 + 8'(k));
        check("t5_full", {28'd0, count}, 32'd8);
        base_o = n_ovf;
        send_frame(8'h44, odd_par(8'h44), 1'b1, 10, -1);
        ps2_data = 1'b1;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(6);
        rd_ready = 1'b1;
        wait_clk(1);
        rd_ready = 1'b0;
        wait_clk(13);
        ps2_clk = 1'b1;
        wait_clk(30);
        check("t5_count_pp", {28'd0, count}, 32'd8);
        check("t5_no_ovf", n_ovf - base_o, 32'd0);
        for (int k = 1; k < 8; k++) begin
            exp_b = 8'h60 + 8'(k);
            pop_expect("t5_drain", exp_b);
        end
        pop_expect("t5_last_44", 8'h44);
        check("t5_empty", {31'd0, rd_valid}, 32'd0);

        // 6a: glitches on ps2_clk in IDLE and in DATA are ignored
        base_p = n_perr;
        base_f = n_ferr;
        send_frame(8'h12, 1'b1, 1'b1, 11, 0);
        wait_clk(20);
        check("t6_idle_glitch_count", {28'd0, count}, 32'd1);
        pop_expect("t6_idle_glitch_data", 8'h12);
        send_frame(8'h12, 1'b1, 1'b1, 11, 5);
        wait_clk(20);
        check("t6_data_glitch_count", {28'd0, count}, 32'd1);
        check("t6_data_glitch_data", {24'd0, rd_data}, 32'h12);
        check("t6_glitch_noerr", (n_perr - base_p) + (n_ferr - base_f), 32'd0);

        // 6b: reset in the middle of a frame with one byte queued
        base_o = n_ovf;
        send_frame(8'h77, 1'b0, 1'b1, 5, -1);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("t6_rst_count", {28'd0, count}, 32'd0);
        check("t6_rst_valid", {31'd0, rd_valid}, 32'd0);
        check("t6_rst_data", {24'd0, rd_data}, 32'h00);
        wait_clk(300);
        check("t6_rst_noerr",
              (n_perr - base_p) + (n_ferr - base_f) + (n_ovf - base_o), 32'd0);
        check("t6_rst_count_later", {28'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
